// File: rtl/disp_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Brief   : Shared constants and active-low 7-segment font for disp_scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_OFF = 8'hFF;
    // Wide enough for the largest legal bank; slice to N_DIGITS at use.
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low segments g..a; the point bit is supplied separately.
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_dec.sv
// ============================================================================
// Module  : seg7_dec
// Brief   : Combinational hex nibble to active-low a..g segment decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_dec
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = font(i_nibble);

endmodule

`default_nettype wire

// File: rtl/disp_scan.sv
// ============================================================================
// Module  : disp_scan
// Brief   : Time-multiplexed common-anode 7-segment scanner with shadow load.
//           Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] hex,
    input  logic [N_DIGITS-1:0]   point,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEGMENT
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DIV_W-1:0]    c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    c_IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_AN_OFF   = AN_OFF[N_DIGITS-1:0];

    logic [4*N_DIGITS-1:0] r_hex;
    logic [N_DIGITS-1:0]   r_point;
    logic [N_DIGITS-1:0]   r_en;
    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;

    logic [N_DIGITS-1:0]   w_blank;
    logic [3:0]            w_nib;
    logic                  w_pt;
    logic [6:0]            w_font;
    logic [N_DIGITS-1:0]   w_an_next;
    logic [7:0]            w_seg_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex   <= '0;
            r_point <= '0;
            r_en    <= '0;
        end else if (load) begin
            r_hex   <= hex;
            r_point <= point;
            r_en    <= digit_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

`ifdef DISP_SCAN_LZB_EN
    // A digit goes dark when it and every more-significant nibble are zero.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
        if (gi == 0) begin : g_lsd
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = (r_hex[4*N_DIGITS-1:4*gi] == '0);
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_nib     = 4'h0;
        w_pt      = 1'b0;
        w_an_next = c_AN_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib = r_hex[4*i +: 4];
                w_pt  = r_point[i];
                if ((r_div != '0) && r_en[i] && !w_blank[i]) begin
                    w_an_next[i] = 1'b0;
                end
            end
        end
    end

    seg7_dec u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_font)
    );

    always_comb begin
        w_seg_next = SEG_OFF;
        if (w_an_next != c_AN_OFF) begin
            w_seg_next = {~w_pt, w_font};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN      <= c_AN_OFF;
            SEGMENT <= SEG_OFF;
        end else begin
            AN      <= w_an_next;
            SEGMENT <= w_seg_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_disp_scan.sv
// ============================================================================
// Module  : tb_disp_scan
// Brief   : Directed plus random check of disp_scan against a cycle-count model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_scan;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   hex = '0;
    logic [3:0]    point = '0;
    logic [3:0]    digit_en = '0;
    logic [3:0]    AN;
    logic [7:0]    SEGMENT;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release plus the loaded shadow values.
    int          cnt = 0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_pt = '0;
    logic [3:0]  m_en = '0;

    logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    disp_scan #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .hex      (hex),
        .point    (point),
        .digit_en (digit_en),
        .AN       (AN),
        .SEGMENT  (SEGMENT)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [7:0] e_seg);
        checks++;
        assert (AN === e_an) else begin
            errors++;
            $error("FAIL %s AN observed %b expected %b (cnt %0d)", tag, AN, e_an, cnt);
        end
        checks++;
        assert (SEGMENT === e_seg) else begin
            errors++;
            $error("FAIL %s SEGMENT observed %h expected %h (cnt %0d)", tag, SEGMENT, e_seg, cnt);
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [3:0] nib;
        int         dv;
        int         ix;
        bit         blank;
        @(posedge clk);
        e_an  = 4'hF;
        e_seg = 8'hFF;
        if (!rst_n) begin
            cnt   = 0;
            m_hex = '0;
            m_pt  = '0;
            m_en  = '0;
        end else begin
            dv  = cnt % SD;
            ix  = (cnt / SD) % ND;
            nib = m_hex[4*ix +: 4];
`ifdef DISP_SCAN_LZB_EN
            blank = (ix > 0) && ((m_hex >> (4*ix)) == 16'h0);
`else
            blank = 1'b0;
`endif
            if (dv != 0 && m_en[ix] && !blank) begin
                e_an[ix] = 1'b0;
                e_seg    = {~m_pt[ix], FONT[nib][6:0]};
            end
            if (load) begin
                m_hex = hex;
                m_pt  = point;
                m_en  = digit_en;
            end
            cnt++;
        end
        #1;
        check_out(tag, e_an, e_seg);
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] e);
        hex      = h;
        point    = p;
        digit_en = e;
        load     = 1'b1;
        step("load");
        load     = 1'b0;
    endtask

    initial begin
        // Reset held, then released with no load: display stays dark.
        for (int i = 0; i < 5; i++) step("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step("dark_after_reset");

        do_load(16'h1234, 4'h0, 4'hF);
        for (int i = 0; i < 32; i++) step("scan_1234");

        do_load(16'h1234, 4'b0100, 4'hF);
        for (int i = 0; i < 16; i++) step("point_d2");

        do_load(16'h1234, 4'b0100, 4'b0101);
        for (int i = 0; i < 16; i++) step("en_0101");

        do_load(16'h0070, 4'h0, 4'hF);
        for (int i = 0; i < 16; i++) step("lead_zero");

        do_load(16'h0000, 4'hF, 4'hF);
        for (int i = 0; i < 16; i++) step("all_zero_pts");

        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            hex      = 16'($urandom);
            point    = 4'($urandom);
            digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step("random");
        end
        load = 1'b0;

        // Asynchronous reset in the middle of digit 2's active slot.
        do_load(16'hABCD, 4'hF, 4'hF);
        for (int i = 0; i < 64; i++) begin
            if (((cnt / SD) % ND) == 2 && (cnt % SD) != 0) break;
            step("seek_idx2");
        end
        checks++;
        assert (((cnt / SD) % ND) == 2 && (cnt % SD) != 0) else begin
            errors++;
            $error("FAIL seek_idx2 observed cnt %0d expected idx 2 active", cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 4'hF, 8'hFF);
        step("reset_hold");
        step("reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step("cleared_after_reset");
        rst_n = 1'b0;
        step("reset_again");
        rst_n = 1'b1;
        do_load(16'h5678, 4'h1, 4'hF);
        for (int i = 0; i < 20; i++) step("restart_digit0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
